// File: rtl/rc4_key_scheduler_pkg.sv
// Shared types and helpers for the parallel RC4 key search.
// Holds the scheduler state encoding and the smallest-key selector.
package rc4_search_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      FOUND,
      EXHAUSTED
   } sched_state_t;

   localparam int DEF_NUM_ENG = 4;
   localparam int DEF_KEY_W   = 24;
   localparam int MAX_KEY_W   = 32;

   typedef logic [MAX_KEY_W-1:0] wide_key_t;

   function automatic wide_key_t min_key(
      input wide_key_t a,
      input wide_key_t b
   );
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/rc4_key_scheduler_if.sv
// Bundle between the codebreaker top level, the scheduler
// and the replicated decrypter datapaths.
interface rc4_key_scheduler_if
   import rc4_search_pkg::*;
#(
   parameter int NUM_ENG = DEF_NUM_ENG,
   parameter int KEY_W   = DEF_KEY_W
) ();

   logic                     start;
   logic [NUM_ENG-1:0]       eng_enable;
   logic [NUM_ENG*KEY_W-1:0] eng_key;
   logic [NUM_ENG-1:0]       eng_done;
   logic [NUM_ENG-1:0]       eng_match;
   logic                     busy;
   logic                     found;
   logic [KEY_W-1:0]         found_key;
   logic                     exhausted;
   logic [15:0]              key_display;

   modport master (
      output start, eng_done, eng_match,
      input  eng_enable, eng_key, busy, found,
      input  found_key, exhausted, key_display
   );

   modport slave (
      input  start, eng_done, eng_match,
      output eng_enable, eng_key, busy, found,
      output found_key, exhausted, key_display
   );

endinterface

// File: rtl/rc4_engine_slot.sv
// One engine slot: busy flag plus the key latched at issue.
// Enable follows the busy flag, so a cleared slot idles a cycle.
module rc4_engine_slot #(
   parameter int KEY_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [KEY_W-1:0] load_key_i,
   input  logic             abort_i,
   input  logic             done_i,
   output logic             enable_o,
   output logic [KEY_W-1:0] key_o
);

   logic             busy_q, busy_d;
   logic [KEY_W-1:0] key_q, key_d;

   // release on done/abort, load only when idle
   always_comb begin
      busy_d = busy_q;
      key_d  = key_q;
      if (busy_q && (done_i || abort_i)) begin
         busy_d = 1'b0;
      end else if (!busy_q && load_i) begin
         busy_d = 1'b1;
         key_d  = load_key_i;
      end
   end

   // slot state register
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         key_q  <= '0;
      end else begin
         busy_q <= busy_d;
         key_q  <= key_d;
      end
   end

   assign enable_o = busy_q;
   assign key_o    = key_q;

endmodule

// File: rtl/rc4_key_scheduler.sv
// Parallel key-search controller: issues keys in order to the
// engine slots and reports the smallest matching key.
module rc4_key_scheduler
   import rc4_search_pkg::*;
#(
   parameter int NUM_ENG = DEF_NUM_ENG,
   parameter int KEY_W   = DEF_KEY_W
) (
   input logic                clk,
   input logic                reset,
   rc4_key_scheduler_if.slave bus
);

   sched_state_t state_q, state_d;

   logic [KEY_W:0]   next_key_q, next_key_d;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic [KEY_W-1:0] found_key_q, found_key_d;

   logic [NUM_ENG-1:0] slot_busy;
   logic [NUM_ENG-1:0] done_v;
   logic [NUM_ENG-1:0] match_v;
   logic [NUM_ENG-1:0] load_v;
   logic [NUM_ENG-1:0] abort_v;
   logic [NUM_ENG-1:0] pend_v;
   logic [KEY_W-1:0]   slot_key [NUM_ENG];

   logic [KEY_W-1:0]   match_min;
   logic               any_match;
   logic               issue_ok;
   logic               taken;
   logic               drain_done;
   logic               all_idle;

   for (genvar i = 0; i < NUM_ENG; i++) begin : g_slot
      rc4_engine_slot #(
         .KEY_W(KEY_W)
      ) u_slot (
         .clk       (clk),
         .reset     (reset),
         .load_i    (load_v[i]),
         .load_key_i(next_key_q[KEY_W-1:0]),
         .abort_i   (abort_v[i]),
         .done_i    (bus.eng_done[i]),
         .enable_o  (slot_busy[i]),
         .key_o     (slot_key[i])
      );
   end

   assign done_v  = bus.eng_done & slot_busy;
   assign match_v = done_v & bus.eng_match;

   // smallest key among this cycle's matching completions
   always_comb begin
      any_match = 1'b0;
      match_min = '1;
      for (int i = 0; i < NUM_ENG; i++) begin
         if (match_v[i]) begin
            any_match = 1'b1;
            match_min = KEY_W'(min_key(
               wide_key_t'(slot_key[i]),
               wide_key_t'(match_min)));
         end
      end
   end

   // candidate update: first match sets it, later ones lower it
   always_comb begin
      cand_d = cand_q;
      if (state_q == RUN && any_match) begin
         cand_d = match_min;
      end else if (state_q == DRAIN && any_match) begin
         cand_d = KEY_W'(min_key(
            wide_key_t'(cand_q),
            wide_key_t'(match_min)));
      end
   end

   // issue encoder, drain aborts and pending-smaller-key scan
   always_comb begin
      issue_ok = (state_q == RUN) && !next_key_q[KEY_W]
               && !any_match;
      load_v   = '0;
      taken    = 1'b0;
      abort_v  = '0;
      pend_v   = '0;
      for (int i = 0; i < NUM_ENG; i++) begin
         if (!taken && !slot_busy[i]) begin
            load_v[i] = issue_ok;
            taken     = 1'b1;
         end
         pend_v[i] = slot_busy[i] && !done_v[i]
                   && (slot_key[i] < cand_d);
         if (state_q == DRAIN && slot_busy[i]
             && slot_key[i] > cand_d) begin
            abort_v[i] = 1'b1;
         end
      end
      drain_done = (state_q == DRAIN) && (pend_v == '0);
      all_idle   = ((slot_busy & ~done_v) == '0);
   end

   // key counter and result register next values
   always_comb begin
      next_key_d = next_key_q;
      if (state_q == IDLE && bus.start) begin
         next_key_d = '0;
      end else if (|load_v) begin
         next_key_d = next_key_q + (KEY_W+1)'(1);
      end
      found_key_d = drain_done ? cand_d : found_key_q;
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         next_key_q  <= '0;
         cand_q      <= '0;
         found_key_q <= '0;
      end else begin
         next_key_q  <= next_key_d;
         cand_q      <= cand_d;
         found_key_q <= found_key_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) state_d = RUN;
         end
         RUN: begin
            if (any_match) begin
               state_d = DRAIN;
            end else if (next_key_q[KEY_W] && all_idle) begin
               state_d = EXHAUSTED;
            end
         end
         DRAIN: begin
            if (drain_done) state_d = FOUND;
         end
         default: state_d = state_q;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.busy      = (state_q == RUN) || (state_q == DRAIN);
      bus.found     = (state_q == FOUND);
      bus.exhausted = (state_q == EXHAUSTED);
   end

   // flatten slot keys onto the engine key bus
   always_comb begin
      bus.eng_key = '0;
      for (int i = 0; i < NUM_ENG; i++) begin
         bus.eng_key[i*KEY_W +: KEY_W] = slot_key[i];
      end
   end

   assign bus.eng_enable = slot_busy;
   assign bus.found_key  = found_key_q;

   if (KEY_W >= 16) begin : g_disp
      assign bus.key_display = next_key_q[KEY_W-1 -: 16];
   end else begin : g_disp_narrow
      assign bus.key_display = 16'(next_key_q[KEY_W-1:0]);
   end

endmodule

// File: tb/tb_rc4_key_scheduler.sv
// Bench for rc4_key_scheduler: hand sequences plus
// random-latency engine runs against a serial-search model.
module tb_rc4_key_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;

   rc4_key_scheduler_if #(.NUM_ENG(4), .KEY_W(24)) bus_a ();
   rc4_key_scheduler_if #(.NUM_ENG(2), .KEY_W(4))  bus_b ();

   rc4_key_scheduler #(.NUM_ENG(4), .KEY_W(24)) dut_a (
      .clk  (clk),
      .reset(rst_a),
      .bus  (bus_a)
   );

   rc4_key_scheduler #(.NUM_ENG(2), .KEY_W(4)) dut_b (
      .clk  (clk),
      .reset(rst_b),
      .bus  (bus_b)
   );

   typedef struct {
      int m0;
      int m1;
      int exp_key;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [7:0] en_s;
   int         key_s [8];
   logic       busy_s, found_s, exh_s;
   int         fk_s, disp_s;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d",
                  nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int d);
      if (d == 0) begin
         en_s = 8'(bus_a.eng_enable);
         for (int i = 0; i < 4; i++)
            key_s[i] = int'(bus_a.eng_key[i*24 +: 24]);
         busy_s = bus_a.busy;
         found_s = bus_a.found;
         exh_s = bus_a.exhausted;
         fk_s = int'(bus_a.found_key);
         disp_s = int'(bus_a.key_display);
      end else begin
         en_s = 8'(bus_b.eng_enable);
         for (int i = 0; i < 2; i++)
            key_s[i] = int'(bus_b.eng_key[i*4 +: 4]);
         busy_s = bus_b.busy;
         found_s = bus_b.found;
         exh_s = bus_b.exhausted;
         fk_s = int'(bus_b.found_key);
         disp_s = int'(bus_b.key_display);
      end
   endtask

   task automatic drive(input int d,
                        input logic [7:0] dn,
                        input logic [7:0] mt);
      if (d == 0) begin
         bus_a.eng_done = dn[3:0];
         bus_a.eng_match = mt[3:0];
      end else begin
         bus_b.eng_done = dn[1:0];
         bus_b.eng_match = mt[1:0];
      end
   endtask

   task automatic do_reset(input int d);
      if (d == 0) begin
         rst_a = 1'b1;
         bus_a.start = 1'b0;
      end else begin
         rst_b = 1'b1;
         bus_b.start = 1'b0;
      end
      drive(d, 8'h0, 8'h0);
      repeat (2) tick();
      rst_a = 1'b0;
      rst_b = 1'b0;
   endtask

   task automatic start_a();
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
   endtask

   // slots 0..3 end up holding keys base..base+3
   task automatic load_to(input int base);
      do_reset(0);
      start_a();
      repeat (4) tick();
      for (int b = 0; b < base; b += 4) begin
         drive(0, 8'h0f, 8'h00);
         tick();
         drive(0, 8'h00, 8'h00);
         repeat (4) tick();
      end
   endtask

   // engines with random latency; result must equal a
   // serial search: smallest key matching m0 or m1
   task automatic run_search(input int d,
                             input int m0,
                             input int m1,
                             input int exp_key,
                             input bit exp_exh,
                             input string tag);
      bit         run [8];
      int         cnt [8];
      int         kk [8];
      logic [7:0] dn, mt, real_dn, prev_real;
      int         n, next_exp, done_lt, issues;
      int         bad_order, bad_stab, bad_gap;
      bit         term;
      n = (d == 0) ? 4 : 2;
      next_exp = 0;
      done_lt = 0;
      bad_order = 0;
      bad_stab = 0;
      bad_gap = 0;
      term = 1'b0;
      prev_real = '0;
      for (int i = 0; i < 8; i++) begin
         run[i] = 1'b0;
         cnt[i] = 0;
         kk[i] = 0;
      end
      do_reset(d);
      if (d == 0) bus_a.start = 1'b1;
      else bus_b.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      for (int cyc = 0; cyc < 3000 && !term; cyc++) begin
         tick();
         sample(d);
         if (found_s || exh_s) begin
            term = 1'b1;
         end else begin
            issues = 0;
            dn = '0;
            mt = '0;
            real_dn = '0;
            for (int i = 0; i < n; i++) begin
               if (en_s[i]) begin
                  if (!run[i]) begin
                     if (prev_real[i]) bad_gap++;
                     run[i] = 1'b1;
                     cnt[i] = $urandom_range(0, 3);
                     kk[i] = key_s[i];
                     if (key_s[i] != next_exp) bad_order++;
                     next_exp++;
                     issues++;
                  end else if (key_s[i] != kk[i]) begin
                     bad_stab++;
                  end
                  if (cnt[i] == 0) begin
                     dn[i] = 1'b1;
                     real_dn[i] = 1'b1;
                     mt[i] = (kk[i] == m0) || (kk[i] == m1);
                     run[i] = 1'b0;
                     if (kk[i] < exp_key) done_lt++;
                  end else begin
                     cnt[i]--;
                     mt[i] = 1'($urandom_range(0, 1));
                  end
               end else begin
                  run[i] = 1'b0;
                  dn[i] = ($urandom_range(0, 3) == 0);
                  mt[i] = 1'($urandom_range(0, 1));
               end
            end
            if (issues > 1) bad_order++;
            drive(d, dn, mt);
            prev_real = real_dn;
         end
      end
      drive(d, 8'h0, 8'h0);
      chk({tag, "_terminated"}, 32'(term), 1);
      chk({tag, "_issue_order"}, bad_order, 0);
      chk({tag, "_key_stable"}, bad_stab, 0);
      chk({tag, "_idle_gap"}, bad_gap, 0);
      chk({tag, "_smaller_done"}, done_lt, exp_key);
      chk({tag, "_enables"}, en_s, 0);
      chk({tag, "_busy"}, 32'(busy_s), 0);
      if (exp_exh) begin
         chk({tag, "_exhausted"}, 32'(exh_s), 1);
         chk({tag, "_found"}, 32'(found_s), 0);
         chk({tag, "_issued"}, next_exp, exp_key);
      end else begin
         chk({tag, "_found"}, 32'(found_s), 1);
         chk({tag, "_found_key"}, fk_s, exp_key);
      end
   endtask

   vec_t tv [5];
   int   r0, r1;

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      drive(0, 8'h0, 8'h0);
      drive(1, 8'h0, 8'h0);

      tv[0] = '{m0: 10, m1: 37, exp_key: 10};
      tv[1] = '{m0: 6,  m1: 5,  exp_key: 5};
      tv[2] = '{m0: 0,  m1: -1, exp_key: 0};
      tv[3] = '{m0: 3,  m1: 2,  exp_key: 2};
      tv[4] = '{m0: -1, m1: 19, exp_key: 19};

      // reset state
      do_reset(0);
      sample(0);
      chk("rst_enable", en_s, 0);
      chk("rst_busy", 32'(busy_s), 0);
      chk("rst_found", 32'(found_s), 0);
      chk("rst_exhausted", 32'(exh_s), 0);
      chk("rst_found_key", fk_s, 0);
      chk("rst_display", disp_s, 0);
      chk("rst_key0", key_s[0], 0);

      // start with no completions: one key per cycle
      start_a();
      sample(0);
      chk("start_no_enable_yet", en_s, 0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         sample(0);
         chk("load_enable", en_s, (1 << c) - 1);
         chk("load_key", key_s[c-1], c - 1);
      end
      chk("load_busy", 32'(busy_s), 1);
      chk("load_display", disp_s, 0);

      // slot 1 finishes without match, idles, reloads key 4
      drive(0, 8'h02, 8'h00);
      tick();
      drive(0, 8'h00, 8'h00);
      sample(0);
      chk("release_enable", en_s, 4'b1101);
      tick();
      sample(0);
      chk("reload_enable", en_s, 4'b1111);
      chk("reload_key", key_s[1], 4);

      // keys 8..11, key 10 matches, 11 aborted, 9 wins
      load_to(8);
      sample(0);
      for (int i = 0; i < 4; i++)
         chk("drain_setup_key", key_s[i], 8 + i);
      drive(0, 8'h04, 8'h04);
      tick();
      drive(0, 8'h00, 8'h00);
      sample(0);
      chk("drain_busy", 32'(busy_s), 1);
      chk("drain_enable", en_s, 4'b1011);
      drive(0, 8'h01, 8'h00);
      tick();
      drive(0, 8'h00, 8'h00);
      sample(0);
      chk("drain_abort", en_s, 4'b0010);
      chk("drain_not_found", 32'(found_s), 0);
      drive(0, 8'h02, 8'h02);
      tick();
      drive(0, 8'h00, 8'h00);
      sample(0);
      chk("drain_found", 32'(found_s), 1);
      chk("drain_found_key", fk_s, 9);
      chk("drain_final_enable", en_s, 0);
      bus_a.start = 1'b1;
      repeat (2) tick();
      bus_a.start = 1'b0;
      sample(0);
      chk("found_ignores_start", 32'(found_s), 1);
      chk("found_ignores_start_en", en_s, 0);

      // keys 5 and 6 match together
      load_to(4);
      drive(0, 8'h06, 8'h06);
      tick();
      drive(0, 8'h00, 8'h00);
      tick();
      sample(0);
      chk("dual_pending", en_s, 4'b0001);
      drive(0, 8'h01, 8'h00);
      tick();
      drive(0, 8'h00, 8'h00);
      sample(0);
      chk("dual_found", 32'(found_s), 1);
      chk("dual_found_key", fk_s, 5);

      // reset while draining
      load_to(4);
      drive(0, 8'h04, 8'h04);
      tick();
      drive(0, 8'h00, 8'h00);
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      sample(0);
      chk("midrst_enable", en_s, 0);
      chk("midrst_busy", 32'(busy_s), 0);
      chk("midrst_found", 32'(found_s), 0);
      chk("midrst_found_key", fk_s, 0);
      start_a();
      tick();
      sample(0);
      chk("midrst_restart_en", en_s, 4'b0001);
      chk("midrst_restart_key", key_s[0], 0);

      // table vectors with random engine latency
      for (int t = 0; t < 5; t++)
         run_search(0, tv[t].m0, tv[t].m1,
                    tv[t].exp_key, 1'b0, "table");

      // random match sets
      for (int t = 0; t < 6; t++) begin
         r0 = $urandom_range(0, 40);
         r1 = $urandom_range(0, 40);
         run_search(0, r0, r1, (r0 < r1) ? r0 : r1,
                    1'b0, "rand");
      end

      // small keyspace: found and exhausted
      r0 = $urandom_range(0, 15);
      run_search(1, r0, -1, r0, 1'b0, "small_found");
      run_search(1, -1, -1, 16, 1'b0 | 1'b1, "exhaust");
      bus_b.start = 1'b1;
      repeat (2) tick();
      bus_b.start = 1'b0;
      sample(1);
      chk("exh_ignores_start", 32'(exh_s), 1);
      chk("exh_ignores_start_busy", 32'(busy_s), 0);
      chk("exh_ignores_start_en", en_s, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
